// File: rtl/ring_cnt_pkg.sv
// Shared types and helpers for the display-scan ring counter family.
package ring_cnt_pkg;

  localparam int unsigned MAX_BITS = 16;

  typedef enum logic {
    BLANK = 1'b0,
    RUN   = 1'b1
  } ring_state_e;

  // Out-of-range lengths fall back to the full ring.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned bits_num);
    return ((len >= 1) && (len <= bits_num)) ? len : bits_num;
  endfunction

  function automatic logic [MAX_BITS-1:0] onehot(input int unsigned idx, input logic act,
                                                 input int unsigned bits_num);
    logic [MAX_BITS-1:0] v;
    v = {MAX_BITS{~act}};
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if ((i == idx) && (i < bits_num)) v[i] = act;
    end
    return v;
  endfunction

endpackage

// File: rtl/ring_scan_cnt_if.sv
// Control and select bus between the refresh logic and the ring counter.
interface ring_scan_cnt_if #(
  parameter int unsigned BITS_NUM = 8,
  parameter int unsigned IDX_W    = $clog2(BITS_NUM)
);
  logic                CE;
  logic                DIR;
  logic [IDX_W:0]      LEN;
  logic                LOAD;
  logic [IDX_W-1:0]    LOAD_IDX;
  logic [BITS_NUM-1:0] Q;
  logic [IDX_W-1:0]    IDX;
  logic                TC;

  modport master (output CE, DIR, LEN, LOAD, LOAD_IDX, input Q, IDX, TC);
  modport slave  (input CE, DIR, LEN, LOAD, LOAD_IDX, output Q, IDX, TC);
endinterface

// File: rtl/ce_prescaler.sv
// Divides a clock-enable stream: STEP fires on every PRESC_DIV-th CE pulse.
module ce_prescaler #(
  parameter int unsigned PRESC_DIV = 1
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic CE,
  input  logic CLR_CNT,
  output logic STEP
);
  localparam int unsigned CNT_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESC_DIV - 1);

  logic [CNT_W-1:0] pc_q, pc_d;

  always_ff @(posedge CLK) begin
    if (!CLR_N) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // STEP is combinational so the counter can act on it in the same cycle.
  always_comb begin
    STEP = CE && (pc_q == TERM);
    pc_d = pc_q;
    if (CLR_CNT)  pc_d = '0;
    else if (CE)  pc_d = STEP ? '0 : pc_q + CNT_W'(1);
  end
endmodule

// File: rtl/ring_scan_cnt.sv
// Programmable-length up/down one-hot ring counter with prescaler and blank state.
module ring_scan_cnt #(
  parameter int unsigned BITS_NUM  = 8,
  parameter logic        ACT_STATE = 1'b1,
  parameter int unsigned IDX_W     = $clog2(BITS_NUM),
  parameter int unsigned PRESC_DIV = 1
) (
  input  logic           CLK,
  input  logic           CLR_N,
  ring_scan_cnt_if.slave bus
);
  import ring_cnt_pkg::*;

  localparam int unsigned LEN_W = IDX_W + 1;

  ring_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, el_m1;
  logic [LEN_W-1:0]    el_c, idx_ext;
  logic [BITS_NUM-1:0] q_q, q_d;
  logic                tc_q, tc_d;
  logic                step;

  ce_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
    .CLK     (CLK),
    .CLR_N   (CLR_N),
    .CE      (bus.CE),
    .CLR_CNT (bus.LOAD),
    .STEP    (step)
  );

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q <= BLANK;
      idx_q   <= '0;
      q_q     <= {BITS_NUM{~ACT_STATE}};
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

  // Next state: LOAD beats step; idx beyond a shrunk length is pulled back in.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tc_d    = 1'b0;
    el_c    = LEN_W'(eff_len(32'(bus.LEN), BITS_NUM));
    el_m1   = IDX_W'(el_c - LEN_W'(1));
    idx_ext = {1'b0, idx_q};

    if (bus.LOAD) begin
      state_d = RUN;
      idx_d   = ({1'b0, bus.LOAD_IDX} < el_c) ? bus.LOAD_IDX : '0;
    end else if (step) begin
      if (state_q == BLANK) begin
        state_d = RUN;
        idx_d   = '0;
      end else if (!bus.DIR) begin
        if (idx_ext >= (el_c - LEN_W'(1))) begin
          idx_d = '0;
          tc_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d = el_m1;
          tc_d  = 1'b1;
        end else if (idx_ext >= el_c) begin
          idx_d = el_m1;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
    end

    q_d = (state_d == RUN) ? BITS_NUM'(onehot(32'(idx_d), ACT_STATE, BITS_NUM))
                           : {BITS_NUM{~ACT_STATE}};
  end

  assign bus.Q   = q_q;
  assign bus.IDX = idx_q;
  assign bus.TC  = tc_q;
endmodule
